// File: rtl/screen_compositor_pkg.sv
// Shared types, VGA timing constants and pixel-format helpers for the
// final compositing stage.
package screen_compositor_pkg;

  typedef enum logic [1:0] {
    SCR_TITLE = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_OVER  = 2'd2
  } scr_state_e;

  // 640x480 @ 60 Hz timing, shared with the sync generator
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Expands each channel by replicating its MSBs into the new low bits.
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

endpackage

// File: rtl/screen_compositor_pipe_delay.sv
// Parameterised WIDTH x DEPTH shift register with a per-bit reset value;
// used to line timing and sprite flags up with the ROM pipeline.
module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: every stage is reset, not just the tap, so the line drains idle
      // values (syncs high, flags low) while it refills after reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/screen_compositor.sv
// Final pixel stage: aligns sprite/ROM/timing, runs the TITLE/PLAY/OVER
// screen machine on frame boundaries and drives 12-bit RGB plus syncs.
module screen_compositor
  import screen_compositor_pkg::*;
#(
  parameter int          PIPE_DLY     = 2,
  parameter logic [7:0]  TRANSP       = 8'hE3,
  parameter logic [11:0] BG_RGB       = 12'hFFF,
  parameter logic [11:0] TILE_RGB     = 12'h000,
  parameter logic [11:0] OVER_BG_RGB  = 12'h400,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        aactive,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        BSpriteOn,
  input  logic        GSpriteOn,
  input  logic [7:0]  dout,
  input  logic [7:0]  gout,
  input  logic        tile_on,
  input  logic        start_btn,
  input  logic        game_over,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [1:0]  scr_state
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  logic [2:0] sync_d;
  logic [1:0] flag_d;
  logic       hs_al, vs_al, act_al, bspr_d, gspr_d;

  // {hsync, vsync, active} delayed to ROM-data time; syncs idle high
  pipe_delay #(.WIDTH(3), .DEPTH(PIPE_DLY), .RST_VAL(3'b110)) u_sync_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     ({hsync_in, vsync_in, aactive}),
    .q     (sync_d)
  );

  // Sprite flags already lead the ROM data by PIPE_DLY-1 cycles
  pipe_delay #(.WIDTH(2), .DEPTH(PIPE_DLY - 1), .RST_VAL(2'b00)) u_flag_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     ({BSpriteOn, GSpriteOn}),
    .q     (flag_d)
  );

  assign {hs_al, vs_al, act_al} = sync_d;
  assign {bspr_d, gspr_d}       = flag_d;

  logic vs_prev, start_prev;
  logic frame_tick, start_rise;

  assign frame_tick = vs_prev & ~vsync_in;
  assign start_rise = start_btn & ~start_prev;

  scr_state_e state, state_nxt;
  logic       pend, req;
  logic       enter_title;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    req       = 1'b0;
    state_nxt = state;
    case (state)
      SCR_TITLE: begin
        req = start_rise;
        if (frame_tick && pend) state_nxt = SCR_PLAY;
      end
      SCR_PLAY: begin
        req = game_over;
        if (frame_tick && pend) state_nxt = SCR_OVER;
      end
      SCR_OVER: begin
        req = start_rise;
        if (frame_tick && pend) state_nxt = SCR_TITLE;
      end
      default: state_nxt = SCR_TITLE;
    endcase
  end

  assign enter_title = (state_nxt == SCR_TITLE) && (state != SCR_TITLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= SCR_TITLE;
      pend       <= 1'b0;
      vs_prev    <= 1'b1;
      start_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state      <= state_nxt;
      vs_prev    <= vsync_in;
      start_prev <= start_btn;
      // A transition consumes the request; otherwise requests accumulate,
      // so one arriving on the boundary cycle waits for the next boundary.
      if (state_nxt != state) pend <= 1'b0;
      else                    pend <= pend | req;
    end
  end

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_vis;

  always_ff @(posedge i_clk) begin
    if (i_rst || enter_title) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_MAX) begin
        blink_cnt <= '0;
        blink_vis <= ~blink_vis;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  logic [11:0] rgb_nxt;

  always_comb begin
    rgb_nxt = '0;
    if (act_al) begin
      case (state)
        SCR_TITLE: rgb_nxt = (bspr_d && blink_vis && (dout != TRANSP))
                             ? rgb332_to_444(dout) : BG_RGB;
        SCR_PLAY:  rgb_nxt = tile_on ? TILE_RGB : BG_RGB;
        SCR_OVER:  rgb_nxt = (gspr_d && (gout != TRANSP))
                             ? rgb332_to_444(gout) : OVER_BG_RGB;
        default:   rgb_nxt = '0;
      endcase
    end
  end

  // Syncs take the same output register as rgb to stay pixel-aligned
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= rgb_nxt;
      hsync_out <= hs_al;
      vsync_out <= vs_al;
    end
  end

  assign scr_state = state;

endmodule

// File: tb/tb_screen_compositor.sv
// Self-checking bench for screen_compositor: shortened raw timing, random
// pixel traffic, directed screen transitions and a history-based model.
module tb_screen_compositor;
  import screen_compositor_pkg::*;

  localparam int BLINK = 32;
  localparam logic [7:0] TRANSP = 8'hE3;
  localparam int H_TOT = 20, H_ACT = 12, HS_BEG = 14, HS_END = 17;
  localparam int V_TOT = 6, V_ACT = 4, VS_LINE = 4;
  localparam int MAXC = 20000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        aactive = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        BSpriteOn = 1'b0, GSpriteOn = 1'b0;
  logic [7:0]  dout = 8'h00, gout = 8'h00;
  logic        tile_on = 1'b0, start_btn = 1'b0, game_over = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
  logic [1:0]  scr_state;

  screen_compositor dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .aactive   (aactive),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .BSpriteOn (BSpriteOn),
    .GSpriteOn (GSpriteOn),
    .dout      (dout),
    .gout      (gout),
    .tile_on   (tile_on),
    .start_btn (start_btn),
    .game_over (game_over),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .scr_state (scr_state)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int cyc = 0, last_rst = -10, hc = 0, vc = 0;
  bit rand_px = 1'b1;

  // Input history indexed by the edge that sampled it
  logic       h_a[MAXC], h_hs[MAXC], h_vs[MAXC], h_b[MAXC], h_g[MAXC];
  logic       h_t[MAXC], h_st[MAXC], h_go[MAXC];
  logic [7:0] h_d[MAXC], h_gd[MAXC];

  // Model: screen index 0/1/2, pending flag, frames since entering TITLE
  int m_state = 0;
  bit m_pend  = 1'b0;
  int m_frames = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [11:0] expand(input logic [7:0] p);
    int r, g, b;
    r = int'(p[7:5]);
    g = int'(p[4:2]);
    b = int'(p[1:0]);
    return 12'(((r * 2 + r / 4) * 256) + ((g * 2 + g / 4) * 16) + b * 5);
  endfunction

  task automatic tick();
    logic        act, bd, gd, vprev, sprev, req, tck, vis, exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    int          e;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    aactive  = (hc < H_ACT) && (vc < V_ACT);
    hsync_in = !((hc >= HS_BEG) && (hc < HS_END));
    vsync_in = (vc != VS_LINE);
    if (rand_px) begin
      BSpriteOn = 1'($urandom_range(1));
      GSpriteOn = 1'($urandom_range(1));
      tile_on   = 1'($urandom_range(1));
      dout      = ($urandom_range(3) == 0) ? TRANSP : 8'($urandom);
      gout      = ($urandom_range(3) == 0) ? TRANSP : 8'($urandom);
    end
    e = cyc;
    h_a[e] = aactive;  h_hs[e] = hsync_in; h_vs[e] = vsync_in;
    h_b[e] = BSpriteOn; h_g[e] = GSpriteOn; h_t[e] = tile_on;
    h_d[e] = dout; h_gd[e] = gout; h_st[e] = start_btn; h_go[e] = game_over;
    @(posedge i_clk);
    #1;
    if (i_rst) begin
      last_rst = e;
      m_state = 0; m_pend = 1'b0; m_frames = 0;
      exp_rgb = 12'h000; exp_hs = 1'b1; exp_vs = 1'b1;
    end else begin
      act    = (e - 2 > last_rst) ? h_a[e-2]  : 1'b0;
      exp_hs = (e - 2 > last_rst) ? h_hs[e-2] : 1'b1;
      exp_vs = (e - 2 > last_rst) ? h_vs[e-2] : 1'b1;
      bd     = (e - 1 > last_rst) ? h_b[e-1]  : 1'b0;
      gd     = (e - 1 > last_rst) ? h_g[e-1]  : 1'b0;
      vis    = ((m_frames / BLINK) % 2) == 0;
      if (!act)              exp_rgb = 12'h000;
      else if (m_state == 0) exp_rgb = (bd && vis && h_d[e] != TRANSP) ? expand(h_d[e]) : 12'hFFF;
      else if (m_state == 1) exp_rgb = h_t[e] ? 12'h000 : 12'hFFF;
      else                   exp_rgb = (gd && h_gd[e] != TRANSP) ? expand(h_gd[e]) : 12'h400;
      vprev = (e - 1 > last_rst) ? h_vs[e-1] : 1'b1;
      sprev = (e - 1 > last_rst) ? h_st[e-1] : 1'b0;
      tck   = vprev && !h_vs[e];
      req   = (m_state == 1) ? h_go[e] : (h_st[e] && !sprev);
      if (tck) begin
        m_frames++;
        if (m_pend) begin
          m_state = (m_state + 1) % 3;
          m_pend  = 1'b0;
          if (m_state == 0) m_frames = 0;
        end else begin
          m_pend = req;
        end
      end else begin
        m_pend = m_pend || req;
      end
    end
    chk("rgb", rgb, exp_rgb);
    chk("hsync_out", 12'(hsync_out), 12'(exp_hs));
    chk("vsync_out", 12'(vsync_out), 12'(exp_vs));
    chk("scr_state", 12'(scr_state), 12'(m_state));
    hc++;
    if (hc == H_TOT) begin
      hc = 0;
      vc = (vc + 1) % V_TOT;
    end
    cyc++;
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(hc == h && vc == v) && n < H_TOT * V_TOT) begin
      tick();
      n++;
    end
  endtask

  // Raw pixel now, sprite flag one cycle later, ROM pixel two cycles later;
  // rgb for that pixel is visible when this returns.
  task automatic probe(input logic g, input logic [7:0] px);
    rand_px = 1'b0;
    BSpriteOn = 1'b0; GSpriteOn = 1'b0; tile_on = 1'b0; dout = 8'h00; gout = 8'h00;
    tick();
    BSpriteOn = !g; GSpriteOn = g;
    tick();
    BSpriteOn = 1'b0; GSpriteOn = 1'b0;
    if (g) gout = px;
    else   dout = px;
    tick();
    rand_px = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1;
    tick();
    chk("reset_rgb", rgb, 12'h000);
    chk("reset_hsync", 12'(hsync_out), 12'h001);
    chk("reset_vsync", 12'(vsync_out), 12'h001);
    chk("reset_state", 12'(scr_state), 12'h000);
    tick();
    i_rst = 1'b0;

    // Idle title screen
    repeat (2 * H_TOT * V_TOT) tick();
    chk("title_idle_state", 12'(scr_state), 12'h000);
    wait_pos(0, 0);
    rand_px = 1'b0;
    BSpriteOn = 1'b0; GSpriteOn = 1'b0; tile_on = 1'b0; dout = 8'h00; gout = 8'h00;
    repeat (3) tick();
    chk("title_bg", rgb, 12'hFFF);
    wait_pos(H_ACT, 0);
    repeat (3) tick();
    chk("title_blank", rgb, 12'h000);
    rand_px = 1'b1;

    // Title sprite pixel and transparency
    wait_pos(0, 1);
    probe(1'b0, 8'hE0);
    chk("title_sprite_e0", rgb, 12'hF00);
    probe(1'b0, TRANSP);
    chk("title_sprite_transp", rgb, 12'hFFF);

    // Start mid-frame: takes effect only on the vsync falling edge
    wait_pos(5, 1);
    start_btn = 1'b1;
    repeat (3) tick();
    start_btn = 1'b0;
    wait_pos(0, VS_LINE);
    chk("start_pre_boundary", 12'(scr_state), 12'h000);
    tick();
    chk("play_entry", 12'(scr_state), 12'h001);
    wait_pos(0, 0);
    rand_px = 1'b0;
    BSpriteOn = 1'b1; GSpriteOn = 1'b0; tile_on = 1'b0; dout = 8'hE0; gout = 8'h00;
    tick();
    tick();
    tile_on = 1'b1;
    tick();
    chk("play_tile", rgb, 12'h000);
    tile_on = 1'b0;
    tick();
    chk("play_bg_ignores_sprite", rgb, 12'hFFF);
    rand_px = 1'b1;

    // game_over exactly on the boundary cycle: applied one frame later
    wait_pos(0, VS_LINE);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk("gameover_on_boundary", 12'(scr_state), 12'h001);
    wait_pos(0, VS_LINE);
    chk("gameover_pre_boundary", 12'(scr_state), 12'h001);
    tick();
    chk("over_entry", 12'(scr_state), 12'h002);
    wait_pos(0, 0);
    probe(1'b1, 8'h1C);
    chk("over_sprite_1c", rgb, 12'h0F0);
    probe(1'b1, TRANSP);
    chk("over_sprite_transp", rgb, 12'h400);

    // Restart, then watch the blink over 65 frames
    wait_pos(5, 1);
    start_btn = 1'b1;
    tick();
    tick();
    start_btn = 1'b0;
    wait_pos(0, VS_LINE);
    tick();
    chk("title_reentry", 12'(scr_state), 12'h000);
    for (int k = 0; k <= 2 * BLINK; k++) begin
      wait_pos(0, 0);
      probe(1'b0, 8'hE0);
      chk($sformatf("blink_frame_%0d", k), rgb, ((k / BLINK) % 2 == 0) ? 12'hF00 : 12'hFFF);
    end

    // Back to OVER, then reset mid-line
    wait_pos(5, 1);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    wait_pos(0, VS_LINE);
    tick();
    wait_pos(5, 1);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    wait_pos(0, VS_LINE);
    tick();
    chk("over_again", 12'(scr_state), 12'h002);
    wait_pos(HS_BEG - 1, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midline_reset_state", 12'(scr_state), 12'h000);
    chk("midline_reset_rgb", rgb, 12'h000);
    chk("midline_reset_hsync", 12'(hsync_out), 12'h001);
    chk("midline_reset_vsync", 12'(vsync_out), 12'h001);
    tick();
    chk("refill_hsync_1", 12'(hsync_out), 12'h001);
    tick();
    chk("refill_hsync_2", 12'(hsync_out), 12'h001);
    tick();
    chk("refill_hsync_low", 12'(hsync_out), 12'h000);

    repeat (2 * H_TOT * V_TOT) tick();
    chk("post_reset_title", 12'(scr_state), 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_compositor.md
Name: screen_compositor

Overview:
- Final pixel stage, directly downstream of the screen/game-over sprite stage. Consumes sprite-on flags and 8-bit ROM pixels, plus the raw VGA timing.
- Aligns sprite flags, ROM data and sync signals to the sprite/ROM pipeline latency.
- Owns the TITLE / PLAY / OVER screen state machine, which changes only at frame boundaries.
- Drives 12-bit RGB and the delayed hsync/vsync to the VGA pins.

Parameters:
- PIPE_DLY, 2, cycles from raw xx/yy/aactive to valid ROM data; also the sync/active delay.
- TRANSP, 8'hE3, RGB332 value treated as transparent (shows background).
- BG_RGB, 12'hFFF, background colour in TITLE and PLAY.
- TILE_RGB, 12'h000, colour of piano tiles in PLAY.
- OVER_BG_RGB, 12'h400, background colour in OVER.
- BLINK_FRAMES, 32, half-period of the title sprite blink, in frames.

Ports:
- i_clk  in  1  pixel clock (25 MHz).
- i_rst  in  1  synchronous active-high reset.
- aactive  in  1  raw active-video flag.
- hsync_in  in  1  raw hsync, active-low.
- vsync_in  in  1  raw vsync, active-low.
- BSpriteOn  in  1  title sprite flag; registered one cycle after xx/yy.
- GSpriteOn  in  1  game-over sprite flag; same timing as BSpriteOn.
- dout  in  8  title ROM pixel, RGB332; 2 cycles after xx/yy.
- gout  in  8  game-over ROM pixel, RGB332; 2 cycles after xx/yy.
- tile_on  in  1  tile-pixel flag from tile logic; already aligned to ROM data.
- start_btn  in  1  debounced start button, level.
- game_over  in  1  one-cycle pulse from game logic.
- rgb  out  12  {R4,G4,B4} to the DAC.
- hsync_out  out  1  hsync delayed PIPE_DLY.
- vsync_out  out  1  vsync delayed PIPE_DLY.
- scr_state  out  2  current screen: 0 TITLE, 1 PLAY, 2 OVER.

Behaviour:
- Reset values:
  - rgb = 0, hsync_out = 1, vsync_out = 1, scr_state = TITLE.
  - All delay lines fill with 1 (syncs) and 0 (active, flags).
  - Blink counter = 0, blink phase = visible, pending request = none.
- Alignment:
  - BSpriteOn and GSpriteOn are delayed 1 cycle so they line up with dout/gout.
  - aactive, hsync_in and vsync_in are delayed PIPE_DLY cycles.
  - rgb is registered, so total latency from raw timing to rgb is PIPE_DLY+1.
  - The syncs get the same +1 register, so rgb, hsync_out and vsync_out stay mutually aligned.
- Frame boundary = falling edge of vsync_in (registered previous-value compare), giving one pulse per frame.
- Requests, latched into a pending register:
  - In TITLE, a rising edge of start_btn latches a start request.
  - In PLAY, a game_over pulse latches an end request.
  - In OVER, a rising edge of start_btn latches a restart request.
- Transitions, applied only on a frame-boundary cycle, which then clears pending:
  - TITLE -> PLAY on start.
  - PLAY -> OVER on end.
  - OVER -> TITLE on restart.
- Request arriving on the frame-boundary cycle itself: it is latched and applied at the next boundary, never lost. A second request before the boundary is ignored.
- Illegal state encoding 3 recovers to TITLE on the next cycle.
- Blink:
  - Frame counter counts frame boundaries and wraps at BLINK_FRAMES-1, toggling the phase.
  - The counter resets to 0 with phase visible on entry to TITLE.
- Pixel select, evaluated on aligned signals:
  - Aligned aactive = 0 -> rgb = 0 (mandatory blanking).
  - TITLE: if BSpriteOn_d && visible && dout != TRANSP, show the converted dout; else BG_RGB.
  - PLAY: tile_on -> TILE_RGB; else BG_RGB. Sprite flags are ignored.
  - OVER: if GSpriteOn_d && gout != TRANSP, show the converted gout; else OVER_BG_RGB.
- RGB332 -> 444 conversion: R = {r[2:0], r[2]}, G = {g[2:0], g[2]}, B = {b[1:0], b[1:0]}.
- Reset asserted mid-frame: the next edge forces all reset values and the state returns to TITLE; syncs go idle-high until the delay lines refill.

Decomposition:
- Shared package holds:
  - screen state enum (TITLE=0, PLAY=1, OVER=2);
  - the rgb332_to_444 function;
  - the 640x480 timing constants shared with the sync generator.
- One sub-module: pipe_delay, a parameterised width/depth shift register with a reset value. It is used for the sync/active delay and the flag delay.

Test Plan:
- Reset, then run 2 frames with start_btn low -> scr_state = 0; rgb = 12'hFFF when active and off-sprite; rgb = 0 when blanking.
- Drive BSpriteOn = 1 with dout = 8'hE0 at raw cycle n -> rgb = 12'hF00 at cycle n+3; with dout = 8'hE3 -> rgb = 12'hFFF.
- Pulse start_btn mid-frame -> scr_state stays 0 until the next vsync_in falling edge, then is 1 on the following cycle; tile_on = 1 -> rgb = 12'h000.
- In PLAY, pulse game_over on the exact frame-boundary cycle -> OVER entered at the next boundary, not the current one; gout = 8'h1C with GSpriteOn -> rgb = 12'h0F0.
- In TITLE with BLINK_FRAMES = 32 -> sprite visible in frames 0-31, background in frames 32-63, visible again in frame 64.
- Assert i_rst for one cycle while in OVER mid-line -> scr_state = 0, rgb = 0, syncs = 1 on the next edge; raw syncs reappear on the outputs 3 cycles later.
